uart_rx_core: RTL
=================

Name: uart_rx_core

Overview:
UART receive engine: serial line in, parallel byte out. Frame format is 8N1-style: 1 start bit, DataBits data bits LSB-first, 1 stop bit, no parity.
- Generates its own oversample tick (OversampleRate ticks per bit) from a clock-count divider.
- Re-aligns the tick phase at every start edge.
- Samples each bit at mid-bit.
- Sits between the board RX pin and the UART register/FIFO interface; pairs with the existing transmit path.

Parameters:
- ClkPerTick, 27, system clocks per oversample tick (50 MHz / 115200 / 16 ≈ 27); legal range ≥ 2.
- OversampleRate, 16, ticks per bit period; must be even, ≥ 4.
- DataBits, 8, data bits per frame; legal range 5..9.

Ports:
- clk_i  input  1  system clock
- reset_ni  input  1  asynchronous active-low reset
- rx_i  input  1  asynchronous serial line, idle high
- data_o  output  DataBits  last correctly framed word; held until the next good frame
- valid_o  output  1  one-cycle pulse, data_o updated this cycle
- frame_err_o  output  1  one-cycle pulse, stop bit sampled low
- busy_o  output  1  high in any state other than IDLE

Behaviour:
- Reset: one clock, reset_ni, asynchronous assertion, active-low. While reset is low:
  - Sync flops are set to 1; state is IDLE; all counters are 0.
  - data_o = 0, valid_o = 0, frame_err_o = 0, busy_o = 0.
- Reset mid-frame aborts the frame with no pulses. After release the block waits in IDLE for a low level on the synced line.
- rx_i passes through a 2-flop synchronizer; the result is rx_s. All decisions use rx_s only.
- Tick generator:
  - Counter runs 0..ClkPerTick-1; tick is a 1-cycle strobe when the counter wraps.
  - Counter is cleared in the cycle the start condition is detected, so the first tick occurs ClkPerTick clocks later.
  - Counter runs only when state ≠ IDLE.
- Sample counter s counts ticks within a bit. Bit counter b counts data bits, 0..DataBits-1.
- States:
  - IDLE: on rx_s = 0, clear tick counter and s, then go to START.
  - START: on the tick where s = OversampleRate/2-1 (mid start bit):
    - rx_s = 1 → false start; go to IDLE with no pulse.
    - rx_s = 0 → clear s and b, go to DATA.
  - DATA: on the tick where s = OversampleRate-1, shift rx_s into the MSB of the shift register (LSB-first) and clear s.
    - b = DataBits-1 → go to STOP.
    - Otherwise b++.
  - STOP: on the tick where s = OversampleRate-1:
    - rx_s = 1 → data_o ← shift register; valid_o = 1 next cycle; go to IDLE.
    - rx_s = 0 → frame_err_o = 1 next cycle; data_o unchanged; go to BREAK.
  - BREAK: wait for rx_s = 1, then go to IDLE. A held-low line (break) yields exactly one frame_err_o, not repeated errors.
- Latency: valid_o / frame_err_o assert 1 clock after the stop-sample tick. A new start may be accepted in the cycle IDLE is re-entered, so back-to-back frames with a single stop bit are received.
- valid_o and frame_err_o are never high together. No handshake: the consumer must capture data_o on valid_o.
- Width rules: tick counter $clog2(ClkPerTick) bits; s counter $clog2(OversampleRate) bits; b counter $clog2(DataBits)+1 bits. All counters wrap only where stated.

Test Plan:
All scenarios use ClkPerTick = 4, OversampleRate = 16, DataBits = 8, so one bit = 64 clocks.
1. Single frame: drive 0x55, 64-clock bits → valid_o is a single 1-cycle pulse with data_o = 0x55 and frame_err_o = 0. The pulse lands 609 ±1 clocks after rx_s first reads low. busy_o is high throughout the frame.
2. Back-to-back frames: drive 0xA3 then 0x0F, with the second start edge immediately after the first stop bit → two valid_o pulses, data_o = 0xA3 then 0x0F. No frame_err_o.
3. Glitch rejection: drive rx_i low for 20 clocks, then high → no valid_o, no frame_err_o. busy_o returns to 0 within 40 clocks.
4. Framing error: drive 0x3C with stop bit 0, then hold the line low for 2000 clocks → exactly one frame_err_o pulse. data_o keeps its previous value and busy_o stays high. Line high then frame 0x81 → valid_o with data_o = 0x81.
5. Reset mid-frame: assert reset_ni during bit 4 of frame 0xFF → all outputs are 0 immediately (asynchronous). After release, the line idles high, then frame 0x12 → valid_o with data_o = 0x12.
6. Baud tolerance: drive bits of 61 clocks and then 67 clocks (≈ ±4.7%), frame 0xC6 each → both received correctly with data_o = 0xC6.

Source files
------------

// File: rtl/uart_rx_core.sv
// UART receive engine: 2-flop synchronized serial input, a self-timed oversample
// tick re-phased at every start edge, mid-bit sampling, LSB-first framing.
module uart_rx_core #(
    parameter int ClkPerTick     = 27,
    parameter int OversampleRate = 16,
    parameter int DataBits       = 8
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    input  logic                rx_i,
    output logic [DataBits-1:0] data_o,
    output logic                valid_o,
    output logic                frame_err_o,
    output logic                busy_o
);
    localparam int TW = $clog2(ClkPerTick);
    localparam int SW = $clog2(OversampleRate);
    localparam int BW = $clog2(DataBits) + 1;

    localparam logic [TW-1:0] TickMax = TW'(ClkPerTick - 1);
    localparam logic [SW-1:0] SMid    = SW'(OversampleRate / 2 - 1);
    localparam logic [SW-1:0] SMax    = SW'(OversampleRate - 1);
    localparam logic [BW-1:0] BMax    = BW'(DataBits - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          sync_q;
    logic                rx_s;
    logic [TW-1:0]       tcnt_q, tcnt_d;
    logic                tick;
    logic [SW-1:0]       s_q, s_d;
    logic [BW-1:0]       b_q, b_d;
    logic [DataBits-1:0] shift_q, shift_d;
    logic [DataBits-1:0] data_q, data_d;
    logic                valid_q, valid_d;
    logic                ferr_q, ferr_d;

    // Sync flops reset high so a released reset never looks like a start edge.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx_i};
        end
    end

    assign rx_s = sync_q[1];

    // Held at zero in IDLE, so the first tick lands ClkPerTick clocks after start detection.
    assign tick = (state_q != S_IDLE) && (tcnt_q == TickMax);

    always_comb begin
        tcnt_d = '0;
        if ((state_q != S_IDLE) && !tick) begin
            tcnt_d = tcnt_q + TW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        b_d     = b_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                s_d = '0;
                if (!rx_s) begin
                    state_d = S_START;
                end
            end

            S_START: begin
                if (tick) begin
                    if (s_q == SMid) begin
                        s_d = '0;
                        b_d = '0;
                        // A start bit that is high again at mid-bit was a glitch.
                        state_d = rx_s ? S_IDLE : S_DATA;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end

            S_DATA: begin
                if (tick) begin
                    if (s_q == SMax) begin
                        s_d     = '0;
                        shift_d = {rx_s, shift_q[DataBits-1:1]};
                        if (b_q == BMax) begin
                            state_d = S_STOP;
                        end else begin
                            b_d = b_q + BW'(1);
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end

            S_STOP: begin
                if (tick) begin
                    if (s_q == SMax) begin
                        s_d = '0;
                        if (rx_s) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = S_BREAK;
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end

            // Park here on a low line so a held break reports only once.
            S_BREAK: begin
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= S_IDLE;
            tcnt_q  <= '0;
            s_q     <= '0;
            b_q     <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            s_q     <= s_d;
            b_q     <= b_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = ferr_q;
    assign busy_o      = (state_q != S_IDLE);

endmodule
